delivery_scheduler: RTL
=======================

DELIVERY_SCHEDULER -- requirements
Module: delivery_scheduler

Interface
REQ-001 Parameter PTR_W, default 3, master read pointer width; matches rptr_in of the delivery top.
REQ-002 Parameter CNT_W, default 8, burst counter width.
REQ-003 Parameter DRAIN_READS, default 4, unified-read pulses that complete one burst drain.
REQ-004 Parameter FILL_TIMEOUT, default 255, maximum LOAD cycles before error.
REQ-005 clk  in  1  single clock; all logic is on the rising edge.
REQ-006 resetn  in  1  synchronous, active-low reset.
REQ-007 start  in  1  pulse that begins a delivery job; sampled only in IDLE.
REQ-008 num_bursts  in  CNT_W  bursts in the job; latched on an accepted start.
REQ-009 abort  in  1  terminates the job; honoured in any state.
REQ-010 rptr_en  in  1  pointer advance request, driven by master_rptr_en.
REQ-011 n4_full  in  1  all lanes filled, driven by n4_full_pos_out.
REQ-012 gure  in  1  unified-read strobe from the delivery top.
REQ-013 select  out  1  load-enable to the delivery top.
REQ-014 rptr_out  out  PTR_W  master read pointer to rptr_in.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 done  out  1  one-cycle pulse when a job completes.
REQ-017 timeout_err  out  1  sticky fill-timeout flag.
REQ-018 burst_cnt  out  CNT_W  bursts completed in the current job.

Function
REQ-019 The FSM SHALL have the states IDLE, LOAD, DRAIN and DONE, registered, with one transition per cycle.
REQ-020 IDLE: select=0; start=1 with num_bursts!=0 SHALL go to LOAD on the next cycle, clear burst_cnt and the timeout counter, and clear timeout_err.
REQ-021 IDLE: start=1 with num_bursts==0 SHALL go to DONE and pulse done exactly once; select never rises.
REQ-022 LOAD: select=1; each cycle with rptr_en=1 SHALL increment rptr_out by 1, wrapping 7->0 (modulo 2^PTR_W).
REQ-023 LOAD: n4_full=1 SHALL move the FSM to DRAIN next cycle; an rptr_en in the same cycle is still applied.
REQ-024 LOAD: the timeout counter increments each cycle; when it reaches FILL_TIMEOUT without n4_full, timeout_err is set and the FSM goes to IDLE with no done pulse.
REQ-025 DRAIN: select=0; rptr_en is ignored; each gure=1 cycle increments a read counter.
REQ-026 DRAIN: on the DRAIN_READS-th gure, burst_cnt increments. The FSM goes to DONE if the new value equals the latched num_bursts; otherwise it goes to LOAD with the read and timeout counters cleared.
REQ-027 DONE: done=1 for exactly one cycle, then the FSM returns to IDLE; burst_cnt holds its final value until the next accepted start.
REQ-028 abort=1 in any state SHALL force IDLE next cycle with select=0 and no done pulse. abort outranks start, n4_full and gure in the same cycle. rptr_out and burst_cnt hold their values.
REQ-029 start while busy=1 SHALL be ignored, and the latched num_bursts is unchanged.
REQ-030 rptr_out persists across jobs; only reset clears it.
REQ-031 All outputs SHALL be registered; select changes one cycle after the state-changing event.

Reset
REQ-032 resetn=0 at a clock edge SHALL force IDLE and set select=0, rptr_out=0, busy=0, done=0, timeout_err=0, burst_cnt=0, and clear all internal counters and the latched num_bursts.
REQ-033 Reset in the middle of a job SHALL abandon it with no done pulse; the first legal start is on the first edge after resetn returns high.

Structure
REQ-034 The shared package delivery_pkg SHALL hold the state enumeration and the default values of PTR_W, CNT_W, DRAIN_READS and FILL_TIMEOUT.
REQ-035 One sub-module, delivery_rptr_counter, SHALL implement the wrapping pointer with an enable; everything else stays in delivery_scheduler.

Verification
REQ-036 Basic job: num_bursts=2, start; 3 rptr_en pulses, then n4_full, then 4 gure; repeat the pattern once -> rptr_out=6, burst_cnt=2, one done pulse, busy low the cycle after done.
REQ-037 Pointer wrap: in LOAD, 9 consecutive rptr_en cycles starting from rptr_out=0 -> rptr_out=1.
REQ-038 Zero length: start with num_bursts=0 -> one done pulse 2 cycles later, select stays 0, burst_cnt=0.
REQ-039 Timeout: num_bursts=1, start, n4_full held 0 -> timeout_err=1 after 255 LOAD cycles, FSM in IDLE, no done; a new start clears timeout_err.
REQ-040 Abort priority: in DRAIN after 3 gure, assert abort together with gure -> IDLE next cycle, burst_cnt=0, no done.
REQ-041 Reset mid-LOAD: resetn=0 for 1 cycle with rptr_out=5 -> all outputs at reset values; start ignored while resetn=0.

Source files
------------

// File: rtl/delivery_pkg.sv
// Shared types and default sizing for the delivery scheduler slice.
// Holds the job FSM state encoding and parameter defaults.
package delivery_pkg;

    localparam int DEF_PTR_W        = 3;
    localparam int DEF_CNT_W        = 8;
    localparam int DEF_DRAIN_READS  = 4;
    localparam int DEF_FILL_TIMEOUT = 255;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/delivery_rptr_counter.sv
// Master read pointer: wraps modulo 2^PTR_W, advances when enabled.
// Cleared only by reset so the position survives across jobs.
module delivery_rptr_counter #(
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             en,
    output logic [PTR_W-1:0] ptr
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/delivery_scheduler.sv
// Delivery job scheduler: sequences LOAD/DRAIN bursts for the delivery top,
// drives the master read pointer and reports completion or fill timeout.
module delivery_scheduler
    import delivery_pkg::*;
#(
    parameter int PTR_W        = DEF_PTR_W,
    parameter int CNT_W        = DEF_CNT_W,
    parameter int DRAIN_READS  = DEF_DRAIN_READS,
    parameter int FILL_TIMEOUT = DEF_FILL_TIMEOUT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [CNT_W-1:0] num_bursts,
    input  logic             abort,
    input  logic             rptr_en,
    input  logic             n4_full,
    input  logic             gure,
    output logic             select,
    output logic [PTR_W-1:0] rptr_out,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [CNT_W-1:0] burst_cnt
);

    localparam int TO_W = $clog2(FILL_TIMEOUT + 1);
    localparam int RD_W = $clog2(DRAIN_READS + 1);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(FILL_TIMEOUT - 1);
    localparam logic [RD_W-1:0] RD_LAST = RD_W'(DRAIN_READS - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] nb_q;
    logic [CNT_W-1:0] nb_nx;
    logic [CNT_W-1:0] bcnt_nx;
    logic [TO_W-1:0]  to_q;
    logic [TO_W-1:0]  to_nx;
    logic [RD_W-1:0]  rd_q;
    logic [RD_W-1:0]  rd_nx;
    logic             err_nx;
    logic             done_nx;
    logic             ptr_en;

    delivery_rptr_counter #(
        .PTR_W (PTR_W)
    ) u_rptr (
        .clk    (clk),
        .resetn (resetn),
        .en     (ptr_en),
        .ptr    (rptr_out)
    );

    always_comb begin
        state_nx = state;
        nb_nx    = nb_q;
        bcnt_nx  = burst_cnt;
        to_nx    = to_q;
        rd_nx    = rd_q;
        err_nx   = timeout_err;
        ptr_en   = 1'b0;
        done_nx  = (state == ST_DONE) && !abort;

        // abort wins over every other input and freezes pointer and counts
        if (abort) begin
            state_nx = ST_IDLE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        nb_nx    = num_bursts;
                        bcnt_nx  = '0;
                        to_nx    = '0;
                        rd_nx    = '0;
                        err_nx   = 1'b0;
                        state_nx = (num_bursts == '0) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    ptr_en = rptr_en;
                    if (n4_full) begin
                        state_nx = ST_DRAIN;
                    end else if (to_q == TO_LAST) begin
                        err_nx   = 1'b1;
                        state_nx = ST_IDLE;
                    end else begin
                        to_nx = to_q + TO_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (gure) begin
                        if (rd_q == RD_LAST) begin
                            rd_nx    = '0;
                            to_nx    = '0;
                            bcnt_nx  = burst_cnt + CNT_W'(1);
                            state_nx = (bcnt_nx == nb_q) ? ST_DONE : ST_LOAD;
                        end else begin
                            rd_nx = rd_q + RD_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state_nx = ST_IDLE;
                end
                default: begin
                    state_nx = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            nb_q        <= '0;
            to_q        <= '0;
            rd_q        <= '0;
            burst_cnt   <= '0;
            timeout_err <= 1'b0;
            select      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nx;
            nb_q        <= nb_nx;
            to_q        <= to_nx;
            rd_q        <= rd_nx;
            burst_cnt   <= bcnt_nx;
            timeout_err <= err_nx;
            select      <= (state_nx == ST_LOAD);
            busy        <= (state_nx != ST_IDLE);
            done        <= done_nx;
        end
    end

endmodule
